wave_record: RTL and testbench



---
 rtl/wave_record.sv | 231 +++++++++++++++++++++++
 tb/tb_wave_record.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_record.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wave_record : mono PCM capture into a canonical 44-byte RIFF/WAVE file      |
// | Optional 8-bit unsigned format: define WAVE_REC_8BIT_EN (adds I_BITS8).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wave_record #(
  parameter logic [31:0] SAMPLE_RATE = 32'd48000,
  parameter logic [16:0] MAX_DATA    = 17'd131028
) (
  input  logic        I_CLK,
  input  logic        I_RSTn,
`ifdef WAVE_REC_8BIT_EN
  input  logic        I_BITS8,
`endif
  input  logic        I_START,
  input  logic        I_STOP,
  input  logic [16:0] I_BASE_ADDR,
  input  logic [15:0] I_SMP,
  input  logic        I_SMP_VALID,
  input  logic        I_WR_RDY,
  output logic [16:0] O_WR_ADDR,
  output logic [7:0]  O_WR_DATA,
  output logic        O_WR_EN,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_OVERRUN,
  output logic [16:0] O_LEN
);

  localparam logic [31:0] c_BYTE_RATE_16 = SAMPLE_RATE * 32'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state, w_next;
  logic        r_start_d;
  logic [16:0] r_base, r_cnt, r_len;
  logic [5:0]  r_off;
  logic [15:0] r_hold;
  logic        r_hold_valid, r_hold_hi, r_overrun;

  logic        w_start_edge, w_at_max, w_leave, w_accept, w_bits8;
  logic        w_wr_en;
  logic [16:0] w_wr_addr;
  logic [7:0]  w_wr_data;
  logic [31:0] w_fix_word;

`ifdef WAVE_REC_8BIT_EN
  logic r_bits8;
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn)
      r_bits8 <= 1'b0;
    else if (r_state == S_IDLE && w_start_edge)
      r_bits8 <= I_BITS8;
  end
  assign w_bits8 = r_bits8;
`else
  assign w_bits8 = 1'b0;
`endif

  function automatic logic [7:0] hdr_byte(input logic [5:0] off, input logic b8);
    logic [31:0] br;
    br = b8 ? SAMPLE_RATE : c_BYTE_RATE_16;
    case (off)
      6'd0:  hdr_byte = 8'h52;
      6'd1:  hdr_byte = 8'h49;
      6'd2:  hdr_byte = 8'h46;
      6'd3:  hdr_byte = 8'h46;
      6'd8:  hdr_byte = 8'h57;
      6'd9:  hdr_byte = 8'h41;
      6'd10: hdr_byte = 8'h56;
      6'd11: hdr_byte = 8'h45;
      6'd12: hdr_byte = 8'h66;
      6'd13: hdr_byte = 8'h6D;
      6'd14: hdr_byte = 8'h74;
      6'd15: hdr_byte = 8'h20;
      6'd16: hdr_byte = 8'h10;
      6'd20: hdr_byte = 8'h01;
      6'd22: hdr_byte = 8'h01;
      6'd24: hdr_byte = SAMPLE_RATE[7:0];
      6'd25: hdr_byte = SAMPLE_RATE[15:8];
      6'd26: hdr_byte = SAMPLE_RATE[23:16];
      6'd27: hdr_byte = SAMPLE_RATE[31:24];
      6'd28: hdr_byte = br[7:0];
      6'd29: hdr_byte = br[15:8];
      6'd30: hdr_byte = br[23:16];
      6'd31: hdr_byte = br[31:24];
      6'd32: hdr_byte = b8 ? 8'd1 : 8'd2;
      6'd34: hdr_byte = b8 ? 8'd8 : 8'd16;
      6'd36: hdr_byte = 8'h64;
      6'd37: hdr_byte = 8'h61;
      6'd38: hdr_byte = 8'h74;
      6'd39: hdr_byte = 8'h61;
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  assign w_start_edge = I_START & ~r_start_d;
  assign w_at_max     = (r_cnt == MAX_DATA);
  // A pending sample is flushed before stopping, except when the buffer is full.
  assign w_leave      = (r_state == S_DATA) && (w_at_max || (I_STOP && !r_hold_valid));
  assign w_accept     = w_wr_en & I_WR_RDY;
  assign w_fix_word   = r_off[2] ? {15'd0, r_cnt} : ({15'd0, r_cnt} + 32'd36);

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_wr_addr = r_base;
    w_wr_data = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) w_next = S_HDR;
      end
      S_HDR: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_base + {11'd0, r_off};
        w_wr_data = hdr_byte(r_off, w_bits8);
        if (I_WR_RDY && r_off == 6'd43) w_next = S_DATA;
      end
      S_DATA: begin
        w_wr_en   = r_hold_valid && !w_at_max;
        w_wr_addr = r_base + 17'd44 + r_cnt;
        if (w_bits8)
          w_wr_data = r_hold[15:8] ^ 8'h80;
        else
          w_wr_data = r_hold_hi ? r_hold[15:8] : r_hold[7:0];
        if (w_leave) w_next = S_FIX;
      end
      S_FIX: begin
        // Index 0-3 patches the RIFF size, 4-7 the data-chunk size.
        w_wr_en   = 1'b1;
        w_wr_addr = r_base + (r_off[2] ? 17'd36 : 17'd4) + {14'd0, r_off[2:0]};
        w_wr_data = w_fix_word[{r_off[1:0], 3'b000} +: 8];
        if (I_WR_RDY && r_off[2:0] == 3'd7) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_start_d    <= 1'b0;
      r_base       <= 17'd0;
      r_cnt        <= 17'd0;
      r_len        <= 17'd0;
      r_off        <= 6'd0;
      r_hold       <= 16'd0;
      r_hold_valid <= 1'b0;
      r_hold_hi    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_start_d <= I_START;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_base       <= I_BASE_ADDR;
            r_len        <= 17'd0;
            r_overrun    <= 1'b0;
            r_off        <= 6'd0;
            r_cnt        <= 17'd0;
            r_hold_valid <= 1'b0;
            r_hold_hi    <= 1'b0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            if (r_off == 6'd43) begin
              r_off <= 6'd0;
              r_cnt <= 17'd0;
            end else begin
              r_off <= r_off + 6'd1;
            end
          end
        end
        S_DATA: begin
          if (I_SMP_VALID && r_hold_valid) r_overrun <= 1'b1;
          if (w_leave) begin
            r_hold_valid <= 1'b0;
            r_hold_hi    <= 1'b0;
            r_off        <= 6'd0;
          end else begin
            if (w_accept) begin
              r_cnt <= r_cnt + 17'd1;
              if (w_bits8 || r_hold_hi) begin
                r_hold_valid <= 1'b0;
                r_hold_hi    <= 1'b0;
              end else begin
                r_hold_hi <= 1'b1;
              end
            end
            if (I_SMP_VALID && !r_hold_valid) begin
              r_hold       <= I_SMP;
              r_hold_valid <= 1'b1;
            end
          end
        end
        S_FIX: begin
          if (w_accept) begin
            r_off <= r_off + 6'd1;
            if (r_off[2:0] == 3'd7) r_len <= r_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  assign O_WR_EN   = w_wr_en;
  assign O_WR_ADDR = w_wr_addr;
  assign O_WR_DATA = w_wr_data;
  assign O_BUSY    = (r_state != S_IDLE);
  assign O_DONE    = (r_state == S_DONE);
  assign O_OVERRUN = r_overrun;
  assign O_LEN     = r_len;

endmodule
`default_nettype wire

// File: tb/tb_wave_record.sv
`default_nettype none
// Testbench for wave_record: RAM scoreboard plus a file-level reference model
// that rebuilds the expected WAV image from the list of accepted samples.
module tb_wave_record;

  logic        clk = 1'b0;
  logic        rstn, start, start4, stop, smp_valid, rdy;
  logic [16:0] base;
  logic [15:0] smp;
`ifdef WAVE_REC_8BIT_EN
  logic        bits8;
`endif

  logic [16:0] wr_addr, len, wr_addr4, len4;
  logic [7:0]  wr_data, wr_data4;
  logic        wr_en, busy, done, overrun, wr_en4, busy4, done4, overrun4;

  int checks = 0;
  int errors = 0;
  int nbytes = 0, nbytes4 = 0, done_cnt = 0, done_cnt4 = 0;
  bit rnd = 1'b0;

  logic [7:0]  mem  [0:131071];
  logic [7:0]  mem4 [0:131071];
  logic [15:0] exp_smp[$];

  always #5 clk = ~clk;

  wave_record u_dut (
    .I_CLK(clk), .I_RSTn(rstn),
`ifdef WAVE_REC_8BIT_EN
    .I_BITS8(bits8),
`endif
    .I_START(start), .I_STOP(stop), .I_BASE_ADDR(base), .I_SMP(smp),
    .I_SMP_VALID(smp_valid), .I_WR_RDY(rdy), .O_WR_ADDR(wr_addr),
    .O_WR_DATA(wr_data), .O_WR_EN(wr_en), .O_BUSY(busy), .O_DONE(done),
    .O_OVERRUN(overrun), .O_LEN(len)
  );

  wave_record #(.MAX_DATA(17'd4)) u_dut4 (
    .I_CLK(clk), .I_RSTn(rstn),
`ifdef WAVE_REC_8BIT_EN
    .I_BITS8(bits8),
`endif
    .I_START(start4), .I_STOP(stop), .I_BASE_ADDR(base), .I_SMP(smp),
    .I_SMP_VALID(smp_valid), .I_WR_RDY(rdy), .O_WR_ADDR(wr_addr4),
    .O_WR_DATA(wr_data4), .O_WR_EN(wr_en4), .O_BUSY(busy4), .O_DONE(done4),
    .O_OVERRUN(overrun4), .O_LEN(len4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus monitor: inputs change 1ns after posedge, so the negedge view is what the next edge uses.
  initial begin
    logic        pend;
    logic [16:0] p_addr;
    logic [7:0]  p_data;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("hold_stable", {wr_en, wr_addr, wr_data}, {1'b1, p_addr, p_data});
        end
        pend   = wr_en && !rdy;
        p_addr = wr_addr;
        p_data = wr_data;
        if (wr_en && rdy) begin
          mem[wr_addr] = wr_data;
          nbytes++;
        end
        if (wr_en4 && rdy) begin
          mem4[wr_addr4] = wr_data4;
          nbytes4++;
        end
        if (done)  done_cnt++;
        if (done4) done_cnt4++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) rdy = ($urandom % 3) != 0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 131072; i++) begin
      mem[i]  = 'x;
      mem4[i] = 'x;
    end
    nbytes = 0; nbytes4 = 0; done_cnt = 0; done_cnt4 = 0;
    exp_smp = {};
  endtask

  task automatic wait_bytes(input int target);
    int k;
    k = 0;
    while (nbytes < target && k < 3000) begin tick(); k++; end
    if (nbytes < target) chk("wait_bytes_timeout", nbytes, target);
  endtask

  task automatic wait_done(input bit sel);
    int k;
    k = 0;
    while ((sel ? done_cnt4 : done_cnt) == 0 && k < 3000) begin tick(); k++; end
    chk("done_seen", (sel ? done_cnt4 : done_cnt) > 0, 1);
  endtask

  task automatic do_start(input logic [16:0] b, input bit sel);
    base = b;
    if (sel) start4 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start4 = 1'b0;
  endtask

  function automatic logic [7:0] rd(input bit sel, input logic [16:0] a);
    return sel ? mem4[a] : mem[a];
  endfunction

  // Builds the expected file image from first principles and compares it byte by byte.
  task automatic check_file(input string name, input logic [16:0] b, input bit b8, input bit sel);
    logic [7:0]  e[$];
    logic [31:0] dlen, riff, sr, br, ba, bits;
    logic [16:0] a;
    dlen = exp_smp.size() * (b8 ? 1 : 2);
    riff = dlen + 36;
    sr   = 48000;
    ba   = b8 ? 1 : 2;
    bits = b8 ? 8 : 16;
    br   = sr * ba;
    e = {8'h52, 8'h49, 8'h46, 8'h46};
    for (int k = 0; k < 4; k++) e.push_back(riff[8*k +: 8]);
    e = {e, 8'h57, 8'h41, 8'h56, 8'h45, 8'h66, 8'h6D, 8'h74, 8'h20};
    e = {e, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    for (int k = 0; k < 4; k++) e.push_back(sr[8*k +: 8]);
    for (int k = 0; k < 4; k++) e.push_back(br[8*k +: 8]);
    e = {e, ba[7:0], 8'h00, bits[7:0], 8'h00, 8'h64, 8'h61, 8'h74, 8'h61};
    for (int k = 0; k < 4; k++) e.push_back(dlen[8*k +: 8]);
    foreach (exp_smp[k]) begin
      if (b8) e.push_back(exp_smp[k][15:8] ^ 8'h80);
      else begin
        e.push_back(exp_smp[k][7:0]);
        e.push_back(exp_smp[k][15:8]);
      end
    end
    foreach (e[i]) begin
      a = b + 17'(i);
      chk($sformatf("%s_byte%0d", name, i), {24'd0, rd(sel, a)}, {24'd0, e[i]});
    end
    chk({name, "_nbytes"}, sel ? nbytes4 : nbytes, 52 + dlen);
    chk({name, "_len"}, sel ? {15'd0, len4} : {15'd0, len}, dlen);
    chk({name, "_done_once"}, sel ? done_cnt4 : done_cnt, 1);
    chk({name, "_busy"}, sel ? busy4 : busy, 0);
  endtask

  // Records a file on the main instance; each sample is offered only after the previous one is written.
  task automatic record(input string name, input logic [16:0] b, input bit b8);
    int per;
    per = b8 ? 1 : 2;
    do_start(b, 1'b0);
    if (exp_smp.size() == 0) stop = 1'b1;
    wait_bytes(44);
    foreach (exp_smp[k]) begin
      smp = exp_smp[k];
      smp_valid = 1'b1;
      tick();
      smp_valid = 1'b0;
      wait_bytes(44 + (k + 1) * per);
    end
    stop = 1'b1;
    wait_done(1'b0);
    stop = 1'b0;
    repeat (3) tick();
    check_file(name, b, b8, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; start4 = 1'b0; stop = 1'b0; smp_valid = 1'b0;
    rdy = 1'b1; base = 17'd0; smp = 16'd0;
`ifdef WAVE_REC_8BIT_EN
    bits8 = 1'b0;
`endif
    clear_all();

    // Reset holds everything quiet even with active inputs.
    for (int i = 0; i < 4; i++) begin
      start = i[0]; smp_valid = 1'b1; smp = 16'($urandom); stop = i[1];
      tick();
    end
    chk("rst_outputs", {wr_en, busy, done, overrun, len}, 21'd0);
    start = 1'b0; smp_valid = 1'b0; stop = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", {wr_en, busy, done, wr_en4, busy4}, 5'd0);

    // Empty file: stop raised during the header.
    clear_all();
    record("empty", 17'd0, 1'b0);

    // Directed sample values.
    clear_all();
    exp_smp = {16'h1234, 16'hFFFE, 16'h8000};
    record("three", 17'd0, 1'b0);
    chk("three_overrun", overrun, 0);

    // Random samples under random back-pressure.
    clear_all();
    for (int i = 0; i < 6; i++) exp_smp.push_back(16'($urandom));
    rnd = 1'b1;
    record("rand", 17'($urandom_range(0, 20000)), 1'b0);
    rnd = 1'b0;
    rdy = 1'b1;

    // Overrun: second strobe while the first sample is still held is dropped.
    clear_all();
    exp_smp = {16'hA55A};
    do_start(17'h00200, 1'b0);
    wait_bytes(44);
    rdy = 1'b0;
    smp = 16'hA55A; smp_valid = 1'b1;
    tick();
    smp = 16'h1111;
    tick();
    smp_valid = 1'b0;
    chk("overrun_set", overrun, 1);
    rnd = 1'b1;
    wait_bytes(46);
    rnd = 1'b0; rdy = 1'b1;
    stop = 1'b1;
    wait_done(1'b0);
    stop = 1'b0;
    repeat (3) tick();
    check_file("ovr", 17'h00200, 1'b0, 1'b0);
    chk("overrun_sticky", overrun, 1);
    clear_all();
    do_start(17'h00300, 1'b0);
    chk("overrun_cleared", overrun, 0);
    stop = 1'b1;
    wait_done(1'b0);
    stop = 1'b0;
    repeat (3) tick();

    // Auto-stop at MAX_DATA=4 with samples every 4 cycles.
    clear_all();
    do_start(17'h00400, 1'b1);
    begin
      int k;
      k = 0;
      while (nbytes4 < 44 && k < 3000) begin tick(); k++; end
      chk("max_hdr", nbytes4 >= 44, 1);
    end
    for (int i = 0; i < 4; i++) begin
      smp = 16'h0101 * 16'(i + 3);
      if (i < 2) exp_smp.push_back(smp);
      smp_valid = 1'b1;
      tick();
      smp_valid = 1'b0;
      repeat (3) tick();
    end
    wait_done(1'b1);
    repeat (3) tick();
    check_file("max", 17'h00400, 1'b0, 1'b1);
    chk("max_overrun", overrun4, 0);

    // Address wrap: offset 16 lands at address 0.
    clear_all();
    exp_smp = {16'hABCD};
    record("wrap", 17'h1FFF0, 1'b0);
    chk("wrap_addr0", {24'd0, mem[17'h00000]}, 32'h10);
    chk("wrap_fix_data", {24'd0, mem[17'h00018]}, 32'h02);

`ifdef WAVE_REC_8BIT_EN
    clear_all();
    bits8 = 1'b1;
    exp_smp = {16'h1234};
    record("b8", 17'h00100, 1'b1);
    chk("b8_data", {24'd0, mem[17'h00100 + 17'd44]}, 32'h92);
    chk("b8_bits", {24'd0, mem[17'h00100 + 17'd34]}, 32'h08);
    bits8 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
